// File: rtl/arp_pkg.sv
// Shared ARP constants, frame layout and FSM state encoding.
// No logic of its own.
// Used by the requester top and its reply parser.
package arp_pkg;

    localparam int MAC_BITS  = 48;
    localparam int IPV4_BITS = 32;

    localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
    localparam logic [15:0] HTYPE_ETH     = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
    localparam logic [15:0] OPER_REQUEST  = 16'h0001;
    localparam logic [15:0] OPER_REPLY    = 16'h0002;
    localparam logic [7:0]  HLEN_ETH      = 8'd6;
    localparam logic [7:0]  PLEN_IPV4     = 8'd4;
    localparam int          FRAME_BYTES   = 42;
    localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;

    typedef logic [MAC_BITS-1:0]  mac_t;
    typedef logic [IPV4_BITS-1:0] ipv4_t;

    // Ethernet header plus IPv4 ARP body; the first member is the first byte on the wire
    typedef struct packed {
        mac_t        dst;
        mac_t        src;
        logic [15:0] ethertype;
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [7:0]  hlen;
        logic [7:0]  plen;
        logic [15:0] oper;
        mac_t        sha;
        ipv4_t       spa;
        mac_t        tha;
        ipv4_t       tpa;
    } arp_frame_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_WAIT,
        S_DONE,
        S_FAIL
    } arp_state_t;

    // Byte idx of the frame in wire order (idx 0 = most significant byte)
    function automatic logic [7:0] frame_byte(input arp_frame_t f, input logic [5:0] idx);
        logic [5:0] rev;
        rev = 6'(FRAME_BYTES - 1) - idx;
        return f[{rev, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/arp_reply_parser.sv
// Streams RX bytes, checks them against the expected ARP reply and captures the sender MAC.
// match pulses one cycle after the cycle in which data_valid_rx is first seen low.
// No backpressure: every valid byte is consumed; the byte counter saturates at 63.
module arp_reply_parser
    import arp_pkg::*;
(
    input  logic        clk_tx,
    input  logic        areset,
    input  mac_t        my_mac,
    input  ipv4_t       my_ipv4,
    input  ipv4_t       target_ip,
    input  logic        data_valid_rx,
    input  logic [7:0]  data_rx,
    output logic        match,
    output mac_t        sha
);

    logic [5:0] cnt;
    logic       ok;
    arp_frame_t ref_frame;
    logic [7:0] exp_byte;
    logic       in_cmp;
    logic       in_sha;

    // Reference reply; the dst/src and SHA bytes are never compared so their contents do not matter
    assign ref_frame = '{dst: '0, src: '0, ethertype: ETHERTYPE_ARP, htype: HTYPE_ETH,
                         ptype: PTYPE_IPV4, hlen: HLEN_ETH, plen: PLEN_IPV4, oper: OPER_REPLY,
                         sha: '0, spa: target_ip, tha: my_mac, tpa: my_ipv4};

    // Select which bytes are compared and which carry the sender MAC
    always_comb begin
        exp_byte = frame_byte(ref_frame, cnt);
        in_sha   = (cnt >= 6'd22) && (cnt <= 6'd27);
        in_cmp   = (cnt >= 6'd12) && (cnt <= 6'(FRAME_BYTES - 1)) && !in_sha;
    end

    // Count bytes, accumulate the match verdict and evaluate once the burst ends
    always_ff @(posedge clk_tx or posedge areset) begin
        if (areset) begin
            cnt   <= '0;
            ok    <= 1'b1;
            match <= 1'b0;
            sha   <= '0;
        end else begin
            match <= 1'b0;
            if (data_valid_rx) begin
                if (cnt != 6'd63) cnt <= cnt + 6'd1;
                if (in_cmp && (data_rx != exp_byte)) ok <= 1'b0;
                if (in_sha) sha <= {sha[MAC_BITS-9:0], data_rx};
            end else if (cnt != 6'd0) begin
                match <= ok && (cnt >= 6'(FRAME_BYTES));
                cnt   <= '0;
                ok    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/arp_requester.sv
// ARP initiator: sends a broadcast request for target_ip, waits for the reply, reports the peer MAC.
// busy/first TX byte one cycle after start; done two cycles after the reply's valid drops.
// TX byte is held until data_ack_tx with no stall limit; RX has no backpressure.
module arp_requester
    import arp_pkg::*;
#(
    parameter int MAC_W       = 48,
    parameter int IPV4_W      = 32,
    parameter int TX_W        = 8,
    parameter int RX_W        = 8,
    parameter int TIMEOUT_CYC = 125000,
    parameter int MAX_RETRY   = 3
) (
    input  logic              clk_tx,
    input  logic              areset,
    input  logic [MAC_W-1:0]  my_mac,
    input  logic [IPV4_W-1:0] my_ipv4,
    input  logic [IPV4_W-1:0] target_ip,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [MAC_W-1:0]  resolved_mac,
    output logic              data_valid_tx,
    output logic [TX_W-1:0]   data_tx,
    input  logic              data_ack_tx,
    input  logic              data_valid_rx,
    input  logic [RX_W-1:0]   data_rx
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    arp_state_t        state;
    arp_state_t        state_nxt;
    logic [5:0]        idx;
    logic [TMR_W-1:0]  timer;
    logic [RTY_W-1:0]  retry_cnt;
    logic [IPV4_W-1:0] tgt_ip;
    arp_frame_t        tx_frame;
    logic              tx_last;
    logic              timeout;
    logic              retry_left;
    logic              match;
    mac_t              sha;

    assign tx_frame = '{dst: MAC_BCAST, src: my_mac, ethertype: ETHERTYPE_ARP, htype: HTYPE_ETH,
                        ptype: PTYPE_IPV4, hlen: HLEN_ETH, plen: PLEN_IPV4, oper: OPER_REQUEST,
                        sha: my_mac, spa: my_ipv4, tha: '0, tpa: tgt_ip};

    assign tx_last    = (idx == 6'(FRAME_BYTES - 1));
    assign timeout    = (timer == TMR_W'(TIMEOUT_CYC - 1));
    assign retry_left = (retry_cnt != RTY_W'(MAX_RETRY));

    arp_reply_parser u_parser (
        .clk_tx        (clk_tx),
        .areset        (areset),
        .my_mac        (my_mac),
        .my_ipv4       (my_ipv4),
        .target_ip     (tgt_ip),
        .data_valid_rx (data_valid_rx),
        .data_rx       (data_rx),
        .match         (match),
        .sha           (sha)
    );

    // State register
    always_ff @(posedge clk_tx or posedge areset) begin
        if (areset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: a reply match takes priority over a coincident timeout
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_TX;
            S_TX:   if (data_ack_tx && tx_last) state_nxt = S_WAIT;
            S_WAIT: begin
                if (match)        state_nxt = S_DONE;
                else if (timeout) state_nxt = retry_left ? S_TX : S_FAIL;
            end
            S_DONE: state_nxt = S_IDLE;
            S_FAIL: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state so reset clears them immediately
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        fail          = 1'b0;
        data_valid_tx = 1'b0;
        data_tx       = '0;
        case (state)
            S_TX: begin
                busy          = 1'b1;
                data_valid_tx = 1'b1;
                data_tx       = frame_byte(tx_frame, idx);
            end
            S_WAIT:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            S_FAIL:  fail = 1'b1;
            default: ;
        endcase
    end

    // Byte index, reply timer, retry count, latched target and result
    always_ff @(posedge clk_tx or posedge areset) begin
        if (areset) begin
            idx          <= '0;
            timer        <= '0;
            retry_cnt    <= '0;
            tgt_ip       <= '0;
            resolved_mac <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tgt_ip    <= target_ip;
                        retry_cnt <= '0;
                        idx       <= '0;
                    end
                end
                S_TX: begin
                    if (data_ack_tx) begin
                        if (tx_last) begin
                            idx   <= '0;
                            timer <= '0;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                S_WAIT: begin
                    timer <= timer + TMR_W'(1);
                    if (match)                      resolved_mac <= sha;
                    else if (timeout && retry_left) retry_cnt    <= retry_cnt + RTY_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arp_requester.sv
// Directed bench for arp_requester with a short timeout and two retries.
// Expected frames are hand-written constants; replies are built from field values.
// Every wait on the DUT is cycle-bounded.
module tb_arp_requester;

    localparam logic [47:0] MY_MAC  = 48'h0002_2301_0203;
    localparam logic [31:0] MY_IP   = 32'hC0A8_0102;
    localparam logic [31:0] TGT     = 32'hC0A8_0101;
    localparam logic [31:0] OTHER   = 32'h0A00_0001;
    localparam logic [47:0] SHA1    = 48'h0001_4200_5F68;
    localparam logic [47:0] SHA3    = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] SHA4    = 48'h1122_3344_5566;
    localparam logic [335:0] EXP_REQ = {48'hFFFF_FFFF_FFFF, 48'h0002_2301_0203, 16'h0806,
                                        16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001,
                                        48'h0002_2301_0203, 32'hC0A8_0102, 48'h0, 32'hC0A8_0101};

    logic        clk_tx = 1'b0;
    logic        areset;
    logic [47:0] my_mac;
    logic [31:0] my_ipv4;
    logic [31:0] target_ip;
    logic        start;
    logic        busy;
    logic        done;
    logic        fail;
    logic [47:0] resolved_mac;
    logic        data_valid_tx;
    logic [7:0]  data_tx;
    logic        data_ack_tx;
    logic        data_valid_rx;
    logic [7:0]  data_rx;

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;
    int stall_err = 0;

    arp_requester #(.TIMEOUT_CYC(100), .MAX_RETRY(2)) dut (
        .clk_tx        (clk_tx),
        .areset        (areset),
        .my_mac        (my_mac),
        .my_ipv4       (my_ipv4),
        .target_ip     (target_ip),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .fail          (fail),
        .resolved_mac  (resolved_mac),
        .data_valid_tx (data_valid_tx),
        .data_tx       (data_tx),
        .data_ack_tx   (data_ack_tx),
        .data_valid_rx (data_valid_rx),
        .data_rx       (data_rx)
    );

    always #4 clk_tx = ~clk_tx;

    always @(posedge clk_tx) if (done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_tx);
        #1;
    endtask

    task automatic check(input string tag, input logic [335:0] obs, input logic [335:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    function automatic logic [335:0] build_reply(input logic [47:0] sha, input logic [31:0] spa,
                                                 input logic [15:0] oper);
        return {MY_MAC, sha, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, oper,
                sha, spa, MY_MAC, MY_IP};
    endfunction

    // Collect one TX frame; optional 3-cycle ack stall before every 4th byte
    task automatic get_frame(input bit stall, output logic [335:0] f, output int n);
        logic [7:0] held;
        int guard;
        f = '0;
        n = 0;
        guard = 0;
        while (n < 42 && guard < 600) begin
            if (data_valid_tx === 1'b1) begin
                if (stall && (n % 4 == 3)) begin
                    data_ack_tx = 1'b0;
                    repeat (3) begin
                        held = data_tx;
                        tick();
                        if (data_tx !== held || data_valid_tx !== 1'b1) stall_err++;
                    end
                    data_ack_tx = 1'b1;
                end
                f = {f[327:0], data_tx};
                n++;
            end
            tick();
            guard++;
        end
    endtask

    // Drive n bytes back to back; bytes past 42 are zero padding
    task automatic send_frame(input logic [335:0] f, input int n);
        logic [335:0] sh;
        sh = f;
        for (int i = 0; i < n; i++) begin
            data_valid_rx = 1'b1;
            data_rx = sh[335:328];
            sh = sh << 8;
            tick();
        end
        data_valid_rx = 1'b0;
        data_rx = 8'h00;
    endtask

    task automatic expect_done(input string tag, input logic [47:0] mac);
        tick();
        check({tag, "_done_early"}, done, 1'b0);
        tick();
        check({tag, "_done"}, {done, busy}, 2'b10);
        check({tag, "_mac"}, resolved_mac, mac);
        tick();
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        logic [335:0] f;
        int n;
        int d0;
        int extra;

        areset = 1'b1;
        my_mac = MY_MAC;
        my_ipv4 = MY_IP;
        target_ip = TGT;
        start = 1'b0;
        data_ack_tx = 1'b1;
        data_valid_rx = 1'b0;
        data_rx = 8'h00;
        repeat (3) tick();
        check("reset_outs", {busy, done, fail, data_valid_tx, data_tx}, 12'h000);
        check("reset_mac", resolved_mac, 48'h0);
        areset = 1'b0;
        tick();

        // Basic resolve with ack tied high
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_resp", {busy, data_valid_tx, data_tx}, {2'b11, 8'hFF});
        get_frame(1'b0, f, n);
        check("req1_len", n, 42);
        check("req1_bytes", f, EXP_REQ);
        check("req1_vld_fall", data_valid_tx, 1'b0);
        send_frame(build_reply(SHA1, TGT, 16'h0002), 42);
        expect_done("resolve", SHA1);
        check("resolve_cnt", done_cnt, 1);

        // Ack stalls
        start = 1'b1;
        tick();
        start = 1'b0;
        get_frame(1'b1, f, n);
        check("stall_len", n, 42);
        check("stall_bytes", f, EXP_REQ);
        check("stall_hold", stall_err, 0);
        send_frame(build_reply(SHA1, TGT, 16'h0002), 42);
        expect_done("stall", SHA1);

        // Non-matching replies spread over the three attempts
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        get_frame(1'b0, f, n);
        send_frame(build_reply(SHA3, 32'hC0A8_0109, 16'h0002), 42);
        tick();
        send_frame(build_reply(SHA3, TGT, 16'h0002), 41);
        repeat (3) tick();
        check("bad_spa_short", {done_cnt, busy}, {d0, 1'b1});
        get_frame(1'b0, f, n);
        check("retx1_bytes", f, EXP_REQ);
        send_frame(build_reply(SHA3, TGT, 16'h0001), 42);
        repeat (3) tick();
        check("bad_oper", {done_cnt, busy}, {d0, 1'b1});
        get_frame(1'b0, f, n);
        check("retx2_bytes", f, EXP_REQ);
        send_frame(build_reply(SHA3, TGT, 16'h0002), 60);
        expect_done("padded", SHA3);

        // No reply: three frames, then fail
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int a = 0; a < 3; a++) begin
            get_frame(1'b0, f, n);
            check($sformatf("noreply_frame%0d", a), {n, f}, {42, EXP_REQ});
        end
        repeat (99) tick();
        check("fail_early", {fail, busy}, 2'b01);
        tick();
        check("fail_pulse", {fail, busy}, 2'b10);
        tick();
        check("fail_clear", fail, 1'b0);
        extra = 0;
        repeat (150) begin
            tick();
            if (data_valid_tx !== 1'b0) extra++;
        end
        check("no_4th_frame", extra, 0);

        // start while busy is ignored; reply landing on the timeout cycle wins
        data_ack_tx = 1'b0;
        start = 1'b1;
        tick();
        target_ip = OTHER;
        tick();
        start = 1'b0;
        data_ack_tx = 1'b1;
        get_frame(1'b0, f, n);
        check("restart_ignored", f, EXP_REQ);
        repeat (56) tick();
        send_frame(build_reply(SHA4, TGT, 16'h0002), 42);
        expect_done("edge_match", SHA4);
        repeat (5) tick();
        check("edge_no_retx", {data_valid_tx, busy}, 2'b00);
        target_ip = TGT;

        // Async reset in the middle of a frame
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("pre_reset_byte20", {data_valid_tx, data_tx}, {1'b1, 8'h00});
        areset = 1'b1;
        #1;
        check("reset_mid_tx", {busy, data_valid_tx, data_tx}, 10'h000);
        check("reset_mid_mac", resolved_mac, 48'h0);
        tick();
        areset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("post_reset_start", {data_valid_tx, data_tx}, {1'b1, 8'hFF});
        get_frame(1'b0, f, n);
        check("post_reset_frame", {n, f}, {42, EXP_REQ});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/arp_requester.md
# arp_requester

ARP initiator for the GbE datapath: on request it transmits an IPv4 ARP request for a target IP, waits for the matching ARP reply, and reports the peer's MAC. It complements the ARP responder on the same link. Both its TX byte stream and its RX byte stream run in the `clk_tx` domain. RX bytes come from the existing RX-to-TX synchronizing FIFO output.

## Interface
- `MAC_W`, 48: hardware address width.
- `IPV4_W`, 32: protocol address width.
- `TX_W`, 8: TX byte width.
- `RX_W`, 8: RX byte width.
- `TIMEOUT_CYC`, 125000: reply wait per attempt, in `clk_tx` cycles (1 ms at 125 MHz).
- `MAX_RETRY`, 3: retransmissions after the first attempt.
- `clk_tx`, in, 1: single clock, 125 MHz.
- `areset`, in, 1: asynchronous, active-high reset.
- `my_mac`, in, MAC_W: own MAC, static.
- `my_ipv4`, in, IPV4_W: own IP, static.
- `target_ip`, in, IPV4_W: IP to resolve. Sampled on an accepted `start`.
- `start`, in, 1: request resolution. Ignored while `busy`.
- `busy`, out, 1: high from the accepted `start` until `done` or `fail`.
- `done`, out, 1: 1-cycle pulse when the reply is matched.
- `fail`, out, 1: 1-cycle pulse when retries are exhausted.
- `resolved_mac`, out, MAC_W: sender MAC of the matched reply. Holds until the next `done`.
- `data_valid_tx`, out, 1: a TX byte is presented.
- `data_tx`, out, TX_W: TX byte.
- `data_ack_tx`, in, 1: MAC accepted the current byte.
- `data_valid_rx`, in, 1: RX byte valid. A frame is a contiguous high burst.
- `data_rx`, in, RX_W: RX byte.

## Operation
- The request frame is 42 bytes, MSB first:
  - dst FF:FF:FF:FF:FF:FF, src `my_mac`, ethertype 0x0806;
  - HTYPE 0x0001, PTYPE 0x0800, HLEN 6, PLEN 4, OPER 0x0001;
  - SHA `my_mac`, SPA `my_ipv4`, THA all zeros, TPA latched target IP.
- FSM states:
  - IDLE: on `start`, latch `target_ip`, clear `retry_cnt`, go to TX.
  - TX: present byte[idx]. On `data_valid_tx && data_ack_tx`, increment idx. After byte 41 is acked, go to WAIT and clear the timer.
  - WAIT: timer increments every cycle.
    - Reply matched: go to DONE.
    - Timer reaches TIMEOUT_CYC-1 with `retry_cnt < MAX_RETRY`: increment `retry_cnt` and go to TX with idx=0.
    - Timer reaches TIMEOUT_CYC-1 with `retry_cnt == MAX_RETRY`: go to FAIL.
  - DONE: pulse `done`, update `resolved_mac`, go to IDLE.
  - FAIL: pulse `fail`, go to IDLE.
- RX parser:
  - Always running. A byte counter increments per valid byte and saturates at 63.
  - Bytes 12..41 are compared or captured on the fly.
  - The frame is evaluated on the cycle after `data_valid_rx` falls, then the counter resets.
- Match requires all of:
  - count ≥ 42 (padding beyond byte 41 is ignored);
  - ethertype 0x0806, HTYPE 1, PTYPE 0x0800, HLEN 6, PLEN 4, OPER 0x0002;
  - SPA == latched target IP;
  - TPA == `my_ipv4`;
  - THA == `my_mac`.
- A match is acted on only in WAIT. Frames completing in IDLE or TX are discarded.

## Timing
- Reset values: all outputs 0 (including `resolved_mac`), FSM in IDLE, RX counter 0.
- `start` high in IDLE at edge N gives:
  - `busy` = 1 at N+1;
  - `data_valid_tx` = 1 with byte 0 (0xFF) at N+1.
- `data_tx` is held stable while `data_ack_tx` is low. There is no limit on ack stall length.
- `data_valid_tx` falls on the edge after byte 41 is acked.
- `data_valid_rx` falls at edge M on a matching reply gives:
  - `done` = 1 and new `resolved_mac` at M+2;
  - `busy` = 0 at M+2 (same cycle as `done`).
- Timeout and match on the same cycle: the match wins.
- `fail` occurs (MAX_RETRY+1)×(42 + ack stalls + TIMEOUT_CYC) cycles after start, within ±1 per attempt. `busy` falls with `fail`.
- `start` while busy: no effect, and `target_ip` is not re-latched.
- `areset` mid-frame: TX aborts immediately (`data_valid_tx` = 0 asynchronously). A partial RX frame is dropped.
- Timer width: $clog2(TIMEOUT_CYC). Retry counter width: $clog2(MAX_RETRY+1).

## Structure
- `arp_pkg` holds:
  - constants ETHERTYPE_ARP=16'h0806, HTYPE_ETH=16'h0001, PTYPE_IPV4=16'h0800, OPER_REQUEST=16'h0001, OPER_REPLY=16'h0002, FRAME_BYTES=42, MAC_BCAST;
  - the FSM state enum typedef.
- Sub-module `arp_reply_parser`: RX byte counter, field comparators, SHA capture. Outputs a 1-cycle `match` strobe and `sha`.
- The request byte mux and the FSM live in the top module.

## Test plan
- Resolve 192.168.1.1:
  - Stimulus: `my_mac`=00:02:23:01:02:03, `my_ipv4`=192.168.1.2, `data_ack_tx` tied to 1.
  - Required: TX bytes FF×6, 00 02 23 01 02 03, 08 06, 00 01 08 00 06 04 00 01, …, C0 A8 01 01.
  - Then a reply from 00:01:42:00:5F:68 gives `resolved_mac`=0x000142005F68 and one `done` pulse.
- Ack stalls: hold `data_ack_tx` low for 3 cycles before every 4th byte → same 42 bytes with no duplication or skips.
- Non-matching replies in WAIT, followed by the correct reply:
  - SPA 192.168.1.9 → no `done`;
  - OPER 0x0001 → no `done`;
  - 41-byte frame → no `done`;
  - 60-byte padded correct reply → `done`.
- No reply, with TIMEOUT_CYC=100 and MAX_RETRY=2 → exactly 3 request frames, then `fail` pulse and `busy`=0.
- Reply ending on the timeout cycle → `done`, no retransmit. `start` pulsed mid-TX → ignored.
- `areset` asserted at TX byte 20 → outputs 0 immediately. After release, a new `start` sends a complete frame from byte 0.
